// File: rtl/gate_panel_pkg.sv
// gate_panel_pkg: mode encoding and the per-channel gate function shared by
// the gate panel top level.
package gate_panel_pkg;

    localparam int MODE_W    = 3;
    localparam int NUM_MODES = 6;

    // Mode codes as shown on mode_led; codes 6 and 7 are never produced.
    typedef enum logic [MODE_W-1:0] {
        MODE_OR   = 3'd0,
        MODE_AND  = 3'd1,
        MODE_XOR  = 3'd2,
        MODE_NAND = 3'd3,
        MODE_NOR  = 3'd4,
        MODE_XNOR = 3'd5
    } mode_e;

    // Two-input gate selected by mode; unused codes behave as OR.
    function automatic logic gate_op(input logic [MODE_W-1:0] mode,
                                     input logic a,
                                     input logic b);
        logic y;
        case (mode)
            MODE_AND:  y = a & b;
            MODE_XOR:  y = a ^ b;
            MODE_NAND: y = ~(a & b);
            MODE_NOR:  y = ~(a | b);
            MODE_XNOR: y = ~(a ^ b);
            default:   y = a | b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/gate_panel_debounced_sw_debounce.sv
// sw_debounce: two-flop synchroniser followed by a mismatch counter. The
// stable level only follows the synchronised input after it has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; a registered copy of the
// stable level drives the output.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic dout_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronise, count consecutive mismatches, and commit the new level.
    // NOTE: every flop here uses <= so all stages sample the pre-edge values;
    // blocking assignments would collapse the synchroniser into one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            level_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q    <= din_i;
            s2_q    <= s1_q;
            level_q <= stable_q;
            if (s2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_q <= s2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign dout_o = level_q;

endmodule

// File: rtl/gate_panel_debounced.sv
// gate_panel_debounced: board top. Debounces 2*CHANNELS switches and the
// mode button, steps a gate-mode FSM on each debounced button press and
// drives one registered LED per channel.
// Optional build macro GATE_PANEL_EVT_CNT_EN enables the saturating LED
// change counter on evt_cnt; without it evt_cnt is tied to zero.
module gate_panel_debounced
    import gate_panel_pkg::*;
#(
    parameter int CHANNELS        = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*CHANNELS-1:0] sw,
    input  logic                  btn_mode,
    output logic [CHANNELS-1:0]   led,
    output logic [MODE_W-1:0]     mode_led,
    output logic [15:0]           evt_cnt
);

    logic [2*CHANNELS-1:0] deb_sw;
    logic                  deb_btn;
    logic                  btn_d_q;
    logic                  btn_rise;
    mode_e                 mode_q;
    mode_e                 mode_d;
    logic [CHANNELS-1:0]   led_q;
    logic [CHANNELS-1:0]   led_d;

    for (genvar g = 0; g < 2*CHANNELS; g++) begin : g_sw_deb
        sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk    (clk),
            .rst    (rst),
            .din_i  (sw[g]),
            .dout_o (deb_sw[g])
        );
    end

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_deb (
        .clk    (clk),
        .rst    (rst),
        .din_i  (btn_mode),
        .dout_o (deb_btn)
    );

    assign btn_rise = deb_btn & ~btn_d_q;

    // Mode FSM next state: advance once per debounced press, wrap after XNOR.
    // NOTE: next state is defaulted to the current state first so no path
    // through this block leaves mode_d unassigned (no latch).
    always_comb begin
        mode_d = mode_q;
        if (btn_rise) begin
            case (mode_q)
                MODE_OR:   mode_d = MODE_AND;
                MODE_AND:  mode_d = MODE_XOR;
                MODE_XOR:  mode_d = MODE_NAND;
                MODE_NAND: mode_d = MODE_NOR;
                MODE_NOR:  mode_d = MODE_XNOR;
                default:   mode_d = MODE_OR;
            endcase
        end
    end

    // Per-channel gate result from the current mode and debounced levels.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            led_d[i] = gate_op(mode_q, deb_sw[2*i], deb_sw[2*i+1]);
        end
    end

    // Mode register, button edge history and LED output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_OR;
            btn_d_q <= 1'b0;
            led_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            btn_d_q <= deb_btn;
            led_q   <= led_d;
        end
    end

    assign led      = led_q;
    assign mode_led = mode_q;

`ifdef GATE_PANEL_EVT_CNT_EN
    logic [15:0] evt_q;
    logic [15:0] evt_d;

    // Count cycles in which the LED register is about to change; saturate.
    always_comb begin
        evt_d = evt_q;
        if ((led_d != led_q) && (evt_q != 16'hFFFF)) begin
            evt_d = evt_q + 16'd1;
        end
    end

    // Event counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= 16'h0000;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_cnt = evt_q;
`else
    assign evt_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_gate_panel_debounced.sv
// Testbench for gate_panel_debounced (CHANNELS=8, DEBOUNCE_CYCLES=4).
// Directed steps from the test plan followed by randomized switch/button
// segments, all checked every cycle against a behavioural model.
module tb_gate_panel_debounced;

    localparam int CH = 8;
    localparam int DC = 4;
    localparam int NI = 2*CH + 1;   // switch inputs plus the button at index 2*CH

`ifdef GATE_PANEL_EVT_CNT_EN
    localparam bit EVT_EN = 1'b1;
`else
    localparam bit EVT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   sw;
    logic          btn_mode;
    logic [7:0]    led;
    logic [2:0]    mode_led;
    logic [15:0]   evt_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    // Behavioural model state.
    bit       lvl  [NI];   // level accepted from the raw sample stream
    int       run  [NI];   // consecutive raw samples disagreeing with lvl
    bit       pd0  [NI];
    bit       pd1  [NI];
    bit       pd2  [NI];
    bit       deb  [NI];   // debounced level as presented to the gate logic
    bit       m_btn_d;
    int       m_mode;
    bit [7:0] m_led;
    int       m_evt;
    logic [15:0] cur_sw;

    always #5 clk = ~clk;

    gate_panel_debounced #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .btn_mode (btn_mode),
        .led      (led),
        .mode_led (mode_led),
        .evt_cnt  (evt_cnt)
    );

    function automatic bit ref_gate(input int mode, input bit a, input bit b);
        case (mode)
            1:       return a & b;
            2:       return a ^ b;
            3:       return !(a & b);
            4:       return !(a | b);
            5:       return !(a ^ b);
            default: return a | b;
        endcase
    endfunction

    // One rising edge of the reference: a new level is accepted once DC raw
    // samples in a row disagree with the current one and becomes visible to
    // the gates three edges later; LEDs register one edge after that.
    task automatic model_edge();
        bit [7:0] nl;
        bit       raw;
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                lvl[k] = 1'b0; run[k] = 0;
                pd0[k] = 1'b0; pd1[k] = 1'b0; pd2[k] = 1'b0; deb[k] = 1'b0;
            end
            m_btn_d = 1'b0;
            m_mode  = 0;
            m_led   = 8'h00;
            m_evt   = 0;
        end else begin
            for (int i = 0; i < CH; i++) nl[i] = ref_gate(m_mode, deb[2*i], deb[2*i+1]);
            if (nl != m_led && m_evt < 65535) m_evt = m_evt + 1;
            m_led = nl;
            if (deb[2*CH] && !m_btn_d) m_mode = (m_mode + 1) % 6;
            m_btn_d = deb[2*CH];
            for (int k = 0; k < NI; k++) begin
                raw = (k == 2*CH) ? btn_mode : sw[k];
                if (raw == lvl[k]) begin
                    run[k] = 0;
                end else begin
                    run[k] = run[k] + 1;
                    if (run[k] == DC) begin
                        lvl[k] = raw;
                        run[k] = 0;
                    end
                end
                deb[k] = pd2[k];
                pd2[k] = pd1[k];
                pd1[k] = pd0[k];
                pd0[k] = lvl[k];
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_miss = n_miss + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, advance the model, compare on the falling edge.
    task automatic step(input bit r, input logic [15:0] s, input bit b);
        rst      = r;
        sw       = s;
        btn_mode = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("led",      32'(led),      32'(m_led));
        check("mode_led", 32'(mode_led), 32'(m_mode));
        check("evt_cnt",  32'(evt_cnt),  EVT_EN ? 32'(m_evt) : 32'd0);
    endtask

    task automatic press(input int hi, input int lo);
        repeat (hi) step(1'b0, cur_sw, 1'b1);
        repeat (lo) step(1'b0, cur_sw, 1'b0);
    endtask

    initial begin
        int len;
        bit b;
        rst      = 1'b1;
        sw       = '0;
        btn_mode = 1'b0;
        cur_sw   = '0;

        // Reset state.
        step(1'b1, 16'h0000, 1'b0);
        step(1'b1, 16'h0000, 1'b0);
        check("rst_led",  32'(led),      32'h00);
        check("rst_mode", 32'(mode_led), 32'd0);
        check("rst_evt",  32'(evt_cnt),  32'd0);

        // Switch latency: visible at edge 3+DC, not one edge earlier.
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 16'h0001, 1'b0);
            if (j == 6) check("lat_edge6", 32'(led), 32'h00);
            if (j == 7) check("lat_edge7", 32'(led), 32'h01);
        end
        check("lat_evt", 32'(evt_cnt), EVT_EN ? 32'd1 : 32'd0);
        repeat (4) step(1'b0, 16'h0001, 1'b0);

        // Glitch shorter than DC on sw[2] is ignored.
        repeat (3)  step(1'b0, 16'h0005, 1'b0);
        repeat (12) step(1'b0, 16'h0001, 1'b0);
        check("glitch_led", 32'(led),     32'h01);
        check("glitch_evt", 32'(evt_cnt), EVT_EN ? 32'd1 : 32'd0);

        // Three presses select NAND.
        cur_sw = 16'h0001;
        repeat (3) press(10, 10);
        check("nand_mode", 32'(mode_led), 32'd3);
        cur_sw = 16'h000F;
        repeat (12) step(1'b0, cur_sw, 1'b0);
        check("nand_led", 32'(led), 32'hFC);

        // Six presses from reset wrap back to OR; a long hold advances once.
        cur_sw = 16'h0000;
        step(1'b1, cur_sw, 1'b0);
        step(1'b1, cur_sw, 1'b0);
        repeat (6) press(10, 10);
        check("wrap_mode", 32'(mode_led), 32'd0);
        repeat (50) step(1'b0, cur_sw, 1'b1);
        check("hold_mode_hi", 32'(mode_led), 32'd1);
        repeat (20) step(1'b0, cur_sw, 1'b0);
        check("hold_mode_lo", 32'(mode_led), 32'd1);

        // Reset in the middle of a debounce restarts it.
        repeat (3) step(1'b0, 16'h0003, 1'b0);
        step(1'b1, 16'h0003, 1'b0);
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 16'h0003, 1'b0);
            if (j == 6) check("rst_lat_edge6", 32'(led), 32'h00);
            if (j == 7) check("rst_lat_edge7", 32'(led), 32'h01);
        end

        // Randomized segments: switch patterns, presses and occasional resets.
        repeat (300) begin
            cur_sw = 16'($urandom);
            len    = $urandom_range(1, 12);
            b      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 60) == 0) step(1'b1, cur_sw, b);
            repeat (len) step(1'b0, cur_sw, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
